// File: rtl/oscnet_pkg.sv
// Shared oscillator-network definitions: monitor state encoding and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package oscnet_pkg;

  // Monitor state encoding, also decoded by the phase/coupling logic.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } osc_state_t;

  // Defaults shared with the neuron's threshold setting, so the lock window
  // tracks the nominal firing period.
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_INT_MIN     = 4;
  localparam int DEF_INT_MAX     = 6;
  localparam int DEF_LOCK_N      = 3;
  localparam int DEF_TIMEOUT_CYC = 12;

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for the neuron spike line: a held-high spike yields one edge.
// Latency: edge is combinational from spike_in, qualified by a 1-cycle history register.
// Backpressure: none; every rising edge is reported.
module spike_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_q;

  // Keep last cycle's spike level to qualify the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_in;
    end
  end

  assign spike_edge = spike_in & ~spike_q;

endmodule

// File: rtl/spike_rx_monitor.sv
// Measures inter-spike intervals, tracks oscillator lock and flags missing spikes/dropped intervals.
// Latency: interval, valid and spike_count update 1 cycle after the rising spike edge.
// Backpressure: single-entry holding register; a new interval while one is unconsumed is dropped (overrun_err).
module spike_rx_monitor
  import oscnet_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int INT_MIN     = DEF_INT_MIN,
  parameter int INT_MAX     = DEF_INT_MAX,
  parameter int LOCK_N      = DEF_LOCK_N,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             clear_err,
  output logic [CNT_W-1:0] interval_out,
  output logic             interval_valid,
  input  logic             interval_ready,
  output logic             locked,
  output logic             miss_err,
  output logic             overrun_err,
  output logic [15:0]      spike_count
);

  localparam int               GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(INT_MIN);
  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(INT_MAX);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(TIMEOUT_CYC);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_N);

  osc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              spike_edge;
  logic              in_range;
  logic              emit;
  logic              timeout;
  logic              accept;

  spike_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .spike_edge (spike_edge)
  );

  // cnt holds cycles since the last edge, so at an edge it is the interval itself.
  assign in_range = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  // The first edge after IDLE only establishes a reference point.
  assign emit     = spike_edge && (state != ST_IDLE);
  // An edge landing exactly on the timeout cycle is a valid (long) interval, not a miss.
  assign timeout  = !spike_edge && (state != ST_IDLE) && (cnt == TMO_CNT);
  assign accept   = !interval_valid || interval_ready;

  // Interval counter: restarts at 1 on every edge, saturates when idle for long.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (spike_edge) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Lock FSM with registered locked output and consecutive in-range counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (spike_edge) begin
            state    <= ST_MEASURE;
            good_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (emit) begin
            if (!in_range) begin
              good_cnt <= '0;
            end else if (good_cnt == GOOD_LAST) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              good_cnt <= GOOD_FULL;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else if (timeout) begin
            state    <= ST_IDLE;
            good_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (emit) begin
            if (!in_range) begin
              state    <= ST_MEASURE;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end else if (timeout) begin
            state    <= ST_IDLE;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          locked   <= 1'b0;
          good_cnt <= '0;
        end
      endcase
    end
  end

  // Output holding register, sticky error flags (set beats clear) and edge tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      interval_out   <= '0;
      interval_valid <= 1'b0;
      overrun_err    <= 1'b0;
      miss_err       <= 1'b0;
      spike_count    <= '0;
    end else begin
      if (emit && accept) begin
        interval_out   <= cnt;
        interval_valid <= 1'b1;
      end else if (interval_ready) begin
        interval_valid <= 1'b0;
      end

      if (emit && !accept) begin
        overrun_err <= 1'b1;
      end else if (clear_err) begin
        overrun_err <= 1'b0;
      end

      if (timeout) begin
        miss_err <= 1'b1;
      end else if (clear_err) begin
        miss_err <= 1'b0;
      end

      if (spike_edge) begin
        spike_count <= spike_count + 16'd1;
      end
    end
  end

endmodule
